trace_capture_ctrl: RTL and testbench

Capture controller that sits directly upstream of the trace sample FIFO. It arms on software command and waits for the AES-start trigger. After a programmable delay it samples the sensor word at a programmable decimation rate for a programmable number of samples. Each sample is pushed through the FIFO write port, and samples dropped at a full FIFO are counted. The FIFO is then drained by the host-side readout.

---
 rtl/trace_capture_pkg.sv | 16 +
 rtl/trace_decim_counter.sv | 30 +++
 rtl/trace_capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_trace_capture_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_pkg.sv
// Shared types and default widths for the trace capture controller.
package trace_capture_pkg;

   localparam int DBITS_DEF = 8;
   localparam int CNT_W_DEF = 16;
   localparam int DECIM_W   = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_DELAY   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/trace_decim_counter.sv
// Reloadable down-counter; o_zero marks a decimation slot or the end of a delay.
module trace_decim_counter
   import trace_capture_pkg::*;
#(
   parameter int W = DECIM_W
) (
   input  logic         i_clock,
   input  logic         i_reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   // Load has priority; the count holds once it reaches zero.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= {W{1'b0}};
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != {W{1'b0}})) begin
         r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign o_zero = (r_count == {W{1'b0}});

endmodule

// File: rtl/trace_capture_ctrl.sv
// Arms on command, waits for a trigger edge, then pushes decimated sensor
// samples into the trace FIFO, never writing while the FIFO reports full.
module trace_capture_ctrl
   import trace_capture_pkg::*;
#(
   parameter int DBITS = DBITS_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_arm,
   input  logic               i_abort,
   input  logic               i_trigger,
   input  logic [CNT_W-1:0]   i_cfg_delay,
   input  logic [CNT_W-1:0]   i_cfg_length,
   input  logic [DECIM_W-1:0] i_cfg_decim,
   input  logic [DBITS-1:0]   i_sample_in,
   input  logic               i_fifo_full,
   output logic               o_fifo_wr,
   output logic [DBITS-1:0]   o_fifo_din,
   output logic               o_busy,
   output logic               o_done,
   output logic [CNT_W-1:0]   o_overflow_cnt
);

   localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e               r_state;
   state_e               w_state_nxt;
   logic                 r_trig_q;
   logic [CNT_W-1:0]     r_delay;
   logic [CNT_W-1:0]     r_len;
   logic [DECIM_W-1:0]   r_decim;
   logic [CNT_W-1:0]     r_sample_cnt;
   logic                 r_wr_pending;
   logic [DBITS-1:0]     r_fifo_din;
   logic [CNT_W-1:0]     r_ovf;
   logic                 w_trig_edge;
   logic                 w_arm_ok;
   logic                 w_slot;
   logic                 w_last;
   logic                 w_busy;
   logic                 w_done;
   logic                 w_decim_zero;
   logic                 w_dly_zero;

   trace_decim_counter #(.W(DECIM_W)) u_decim (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_load     (w_arm_ok | w_slot),
      .i_load_val (w_arm_ok ? {DECIM_W{1'b0}} : r_decim),
      .i_dec      ((r_state == ST_CAPTURE) & ~w_slot),
      .o_zero     (w_decim_zero)
   );

   // Delay counter starts at delay-1 so DELAY lasts exactly `delay` cycles.
   trace_decim_counter #(.W(CNT_W)) u_delay (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_load     ((r_state == ST_ARMED) & w_trig_edge),
      .i_load_val (r_delay - ONE_C),
      .i_dec      (r_state == ST_DELAY),
      .o_zero     (w_dly_zero)
   );

   // State register; trigger_q resets high so a held trigger cannot fire.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= ST_IDLE;
         r_trig_q <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_trig_q <= i_trigger;
      end
   end

   // Next-state logic; abort overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      if (i_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (i_arm) w_state_nxt = ST_ARMED; else w_state_nxt = ST_IDLE;
            ST_ARMED: begin
               if (!w_trig_edge)                  w_state_nxt = ST_ARMED;
               else if (r_len == {CNT_W{1'b0}})   w_state_nxt = ST_DONE;
               else if (r_delay == {CNT_W{1'b0}}) w_state_nxt = ST_CAPTURE;
               else                               w_state_nxt = ST_DELAY;
            end
            ST_DELAY:   if (w_dly_zero) w_state_nxt = ST_CAPTURE; else w_state_nxt = ST_DELAY;
            ST_CAPTURE: if (w_slot && w_last) w_state_nxt = ST_DONE; else w_state_nxt = ST_CAPTURE;
            ST_DONE:    if (i_arm) w_state_nxt = ST_ARMED; else w_state_nxt = ST_DONE;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State-decoded strobes and status.
   always_comb begin
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_slot      = 1'b0;
      w_trig_edge = i_trigger & ~r_trig_q;
      w_last      = (r_sample_cnt == (r_len - ONE_C));
      w_arm_ok    = i_arm & ~i_abort & ((r_state == ST_IDLE) | (r_state == ST_DONE));
      case (r_state)
         ST_ARMED:   w_busy = 1'b1;
         ST_DELAY:   w_busy = 1'b1;
         ST_CAPTURE: begin
            w_busy = 1'b1;
            w_slot = w_decim_zero;
         end
         ST_DONE:    w_done = 1'b1;
         default:    w_busy = 1'b0;
      endcase
   end

   // Configuration, sample pipeline and overflow accounting.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_delay      <= {CNT_W{1'b0}};
         r_len        <= {CNT_W{1'b0}};
         r_decim      <= {DECIM_W{1'b0}};
         r_sample_cnt <= {CNT_W{1'b0}};
         r_wr_pending <= 1'b0;
         r_fifo_din   <= {DBITS{1'b0}};
         r_ovf        <= {CNT_W{1'b0}};
      end else begin
         if (w_arm_ok) begin
            r_delay <= i_cfg_delay;
            r_len   <= i_cfg_length;
            r_decim <= i_cfg_decim;
         end
         if (w_arm_ok)    r_sample_cnt <= {CNT_W{1'b0}};
         else if (w_slot) r_sample_cnt <= r_sample_cnt + ONE_C;
         if (w_slot) r_fifo_din <= i_sample_in;
         r_wr_pending <= w_slot & ~i_abort;
         // A pending sample meeting a full FIFO is dropped, never written.
         if (w_arm_ok)
            r_ovf <= {CNT_W{1'b0}};
         else if (r_wr_pending && i_fifo_full && (r_ovf != {CNT_W{1'b1}}))
            r_ovf <= r_ovf + ONE_C;
      end
   end

   assign o_fifo_wr      = r_wr_pending & ~i_fifo_full;
   assign o_fifo_din     = r_fifo_din;
   assign o_busy         = w_busy;
   assign o_done         = w_done;
   assign o_overflow_cnt = r_ovf;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Randomized self-checking bench; expected writes come from slot-time arithmetic.
module tb_trace_capture_ctrl;

   localparam int DBITS = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             arm;
   logic             abort;
   logic             trigger;
   logic [CNT_W-1:0] cfg_delay;
   logic [CNT_W-1:0] cfg_length;
   logic [7:0]       cfg_decim;
   logic [DBITS-1:0] sample_in;
   logic             fifo_full;
   logic             fifo_wr;
   logic [DBITS-1:0] fifo_din;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   trace_capture_ctrl #(.DBITS(DBITS), .CNT_W(CNT_W)) dut (
      .i_clock        (clk),
      .i_reset_n      (rst_n),
      .i_arm          (arm),
      .i_abort        (abort),
      .i_trigger      (trigger),
      .i_cfg_delay    (cfg_delay),
      .i_cfg_length   (cfg_length),
      .i_cfg_decim    (cfg_decim),
      .i_sample_in    (sample_in),
      .i_fifo_full    (fifo_full),
      .o_fifo_wr      (fifo_wr),
      .o_fifo_din     (fifo_din),
      .o_busy         (busy),
      .o_done         (done),
      .o_overflow_cnt (ovf)
   );

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic arm_cfg(input int d, input int l, input int m);
      cfg_delay  = CNT_W'(d);
      cfg_length = CNT_W'(l);
      cfg_decim  = 8'(m);
      arm        = 1'b1;
      next_cyc();
      arm        = 1'b0;
   endtask

   // Full capture against the slot model: slot s at cycle 1+d+s*(m+1), write one later.
   task automatic run_capture(input int d, input int l, input int m, input int fmode, input int ab);
      int          ts[$];
      logic [7:0]  samp[0:255];
      int          end_c;
      int          drops;
      int          widx;
      bit          full_k;
      bit          exp_wr;
      bit          exp_done;
      bit          exp_busy;
      for (int s = 0; s < l; s++) ts.push_back(1 + d + s * (m + 1));
      end_c = (l == 0) ? 1 : ts[l-1] + 1;
      trigger = 1'b0;
      abort   = 1'b0;
      arm_cfg(d, l, m);
      cfg_delay  = CNT_W'($urandom);
      cfg_length = CNT_W'($urandom);
      cfg_decim  = 8'($urandom);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || ovf !== 16'd0 || fifo_wr !== 1'b0) begin
         failures++;
         $display("FAIL armed_state: busy=%0b done=%0b ovf=%0d wr=%0b, want busy=1 done=0 ovf=0 wr=0",
                  busy, done, ovf, fifo_wr);
      end
      drops = 0;
      for (int k = 0; k <= end_c + 3; k++) begin
         next_cyc();
         trigger   = (k == 0) ? 1'b1 : 1'($urandom);
         sample_in = 8'($urandom);
         samp[k]   = sample_in;
         cfg_delay  = CNT_W'($urandom);
         cfg_length = CNT_W'($urandom);
         cfg_decim  = 8'($urandom);
         widx = -1;
         for (int s = 0; s < l; s++)
            if (ts[s] + 1 == k && (ab < 0 || k <= ab)) widx = s;
         case (fmode)
            1:       full_k = 1'($urandom);
            2:       full_k = (widx == 1 || widx == 2);
            default: full_k = 1'b0;
         endcase
         fifo_full = full_k;
         abort     = (k == ab);
         arm       = (k < end_c && (ab < 0 || k < ab)) ? ($urandom_range(0, 3) == 0) : 1'b0;
         exp_wr    = (widx >= 0) && !full_k;
         exp_done  = (ab >= 0 && k > ab) ? 1'b0 : (k >= end_c);
         exp_busy  = (ab >= 0 && k > ab) ? 1'b0 : !exp_done;
         @(negedge clk);
         checks++;
         if (fifo_wr !== exp_wr) begin
            failures++;
            $display("FAIL wr_k%0d: fifo_wr=%0b want %0b (d=%0d l=%0d m=%0d full=%0b)",
                     k, fifo_wr, exp_wr, d, l, m, full_k);
         end
         if (exp_wr) begin
            checks++;
            if (fifo_din !== samp[k-1]) begin
               failures++;
               $display("FAIL din_k%0d: fifo_din=%0h want %0h", k, fifo_din, samp[k-1]);
            end
         end
         checks++;
         if (done !== exp_done || busy !== exp_busy || ovf !== 16'(drops)) begin
            failures++;
            $display("FAIL status_k%0d: done=%0b busy=%0b ovf=%0d want done=%0b busy=%0b ovf=%0d",
                     k, done, busy, ovf, exp_done, exp_busy, drops);
         end
         if (widx >= 0 && full_k) drops++;
      end
      next_cyc();
      arm = 1'b0; abort = 1'b0; trigger = 1'b0; fifo_full = 1'b0;
      next_cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b1;
      cfg_delay = 16'd0; cfg_length = 16'd0; cfg_decim = 8'd0;
      sample_in = 8'd0; fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (fifo_wr !== 1'b0 || fifo_din !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs: wr=%0b din=%0h busy=%0b done=%0b ovf=%0d, want all 0",
                  fifo_wr, fifo_din, busy, done, ovf);
      end
      next_cyc();
      rst_n = 1'b1;
      next_cyc();
      arm_cfg(0, 2, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || fifo_wr !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL held_trigger_%0d: busy=%0b wr=%0b done=%0b, want 1 0 0", i, busy, fifo_wr, done);
         end
         next_cyc();
      end
      trigger = 1'b0;
      next_cyc();
      trigger = 1'b1;
      next_cyc();
      @(negedge clk);
      checks++;
      if (fifo_wr !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL retrig_t1: wr=%0b busy=%0b, want 0 1", fifo_wr, busy);
      end
      next_cyc();
      @(negedge clk);
      checks++;
      if (fifo_wr !== 1'b1) begin
         failures++;
         $display("FAIL retrig_t2: wr=%0b, want 1", fifo_wr);
      end
      next_cyc();
      @(negedge clk);
      checks++;
      if (fifo_wr !== 1'b1 || done !== 1'b1) begin
         failures++;
         $display("FAIL retrig_t3: wr=%0b done=%0b, want 1 1", fifo_wr, done);
      end
      trigger = 1'b0;
      next_cyc();
   endtask

   task automatic test_reset_mid_capture();
      arm_cfg(0, 8, 0);
      trigger = 1'b1;
      next_cyc();
      next_cyc();
      next_cyc();
      @(negedge clk);
      checks++;
      if (fifo_wr !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: wr=%0b, want 1", fifo_wr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (fifo_wr !== 1'b0 || fifo_din !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 16'd0) begin
         failures++;
         $display("FAIL mid_reset: wr=%0b din=%0h busy=%0b done=%0b ovf=%0d, want all 0",
                  fifo_wr, fifo_din, busy, done, ovf);
      end
      next_cyc();
      trigger = 1'b0;
      rst_n   = 1'b1;
      next_cyc();
   endtask

   task automatic test_abort();
      run_capture(0, 8, 0, 0, 3);
      arm = 1'b1; abort = 1'b1;
      next_cyc();
      arm = 1'b0; abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         trigger = (i == 1);
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || fifo_wr !== 1'b0) begin
            failures++;
            $display("FAIL arm_abort_%0d: busy=%0b done=%0b wr=%0b, want 0 0 0", i, busy, done, fifo_wr);
         end
         next_cyc();
      end
      trigger = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++)
         run_capture($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3), 1, -1);
   endtask

   initial begin
      test_reset();
      test_reset_mid_capture();
      run_capture(0, 4, 0, 0, -1);
      run_capture(3, 3, 2, 0, -1);
      run_capture(0, 5, 0, 2, -1);
      run_capture(0, 0, 0, 0, -1);
      test_abort();
      run_capture(2, 3, 1, 1, -1);
      run_capture(4, 2, 0, 1, -1);
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
